// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Purpose  : Data-memory request/acknowledge bus between the MEM stage and
//            the data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM pipeline stage. Drives data memory over req/ack, stalls
//            upstream while an access is pending, loads the MEM/WB register.
//            Optional MEM_ALIGN_CHECK_EN rejects misaligned memory accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  input  wire logic [DATA_W-1:0] ALUResult_i,
  input  wire logic [DATA_W-1:0] RDData_i,
  input  wire logic [4:0]        RDaddr_i,
  input  wire logic              RegWrite_i,
  input  wire logic              MemToReg_i,
  input  wire logic              MemWrite_i,
  output logic                   stall_o,
  mem_access_stage_if.master     mem,
  output logic [DATA_W-1:0]      ALUResult_o,
  output logic [DATA_W-1:0]      ReadData_o,
  output logic [4:0]             RDaddr_o,
  output logic                   RegWrite_o,
  output logic                   MemToReg_o,
  output logic                   err_o,
  output logic                   misalign_o
);

  localparam int                 c_CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              state_q;
  logic [c_CNT_W-1:0]  cnt_q;
  logic                req_q;
  logic                we_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   alu_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [4:0]          rd_q;
  logic                regwrite_q;
  logic                memtoreg_q;
  logic                err_q;
  logic                misalign_q;

  logic                w_memop;
  logic                w_misaligned;
  logic                w_expire;

  assign w_memop = MemWrite_i | MemToReg_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = w_memop & (ALUResult_i[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // Ack on the final BUSY cycle takes priority over the timeout.
  assign w_expire = (state_q == S_BUSY) && (cnt_q == c_CNT_LAST) && !mem.ack;

  always_comb begin
    stall_o = 1'b0;
    if (state_q == S_IDLE) begin
      stall_o = w_memop & ~w_misaligned;
    end else begin
      stall_o = ~mem.ack & ~w_expire;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (w_misaligned) begin
            alu_q      <= ALUResult_i;
            rdata_q    <= '0;
            rd_q       <= RDaddr_i;
            regwrite_q <= 1'b0;
            memtoreg_q <= MemToReg_i;
            misalign_q <= 1'b1;
          end else if (w_memop) begin
            req_q      <= 1'b1;
            we_q       <= MemWrite_i;
            addr_q     <= ALUResult_i;
            wdata_q    <= RDData_i;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            state_q    <= S_BUSY;
          end else begin
            alu_q      <= ALUResult_i;
            rdata_q    <= '0;
            rd_q       <= RDaddr_i;
            regwrite_q <= RegWrite_i;
            memtoreg_q <= MemToReg_i;
          end
        end
        S_BUSY: begin
          if (mem.ack) begin
            alu_q      <= ALUResult_i;
            rdata_q    <= mem.rdata;
            rd_q       <= RDaddr_i;
            regwrite_q <= RegWrite_i;
            memtoreg_q <= MemToReg_i;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
          end else if (w_expire) begin
            alu_q      <= ALUResult_i;
            rdata_q    <= '0;
            rd_q       <= RDaddr_i;
            regwrite_q <= 1'b0;
            memtoreg_q <= MemToReg_i;
            req_q      <= 1'b0;
            err_q      <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
          end else begin
            cnt_q      <= cnt_q + 1'b1;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.req     = req_q;
  assign mem.we      = we_q;
  assign mem.addr    = addr_q;
  assign mem.wdata   = wdata_q;
  assign ALUResult_o = alu_q;
  assign ReadData_o  = rdata_q;
  assign RDaddr_o    = rd_q;
  assign RegWrite_o  = regwrite_q;
  assign MemToReg_o  = memtoreg_q;
  assign err_o       = err_q;
  assign misalign_o  = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Directed and randomized bench for mem_access_stage against a
//            transaction-level model of stall length, MEM/WB contents and err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TO = 16;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ALUResult_i, RDData_i;
  logic [4:0]  RDaddr_i;
  logic        RegWrite_i, MemToReg_i, MemWrite_i;
  logic        stall_o;
  logic [31:0] ALUResult_o, ReadData_o;
  logic [4:0]  RDaddr_o;
  logic        RegWrite_o, MemToReg_o, err_o, misalign_o;

  int checks   = 0;
  int failures = 0;
  bit err_model = 1'b0;

  mem_access_stage_if #(.DATA_W(32)) mem_bus ();

  mem_access_stage #(.DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ALUResult_i (ALUResult_i),
    .RDData_i    (RDData_i),
    .RDaddr_i    (RDaddr_i),
    .RegWrite_i  (RegWrite_i),
    .MemToReg_i  (MemToReg_i),
    .MemWrite_i  (MemWrite_i),
    .stall_o     (stall_o),
    .mem         (mem_bus),
    .ALUResult_o (ALUResult_o),
    .ReadData_o  (ReadData_o),
    .RDaddr_o    (RDaddr_o),
    .RegWrite_o  (RegWrite_o),
    .MemToReg_o  (MemToReg_o),
    .err_o       (err_o),
    .misalign_o  (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                            input bit rw, input bit m2r, input bit mw);
    ALUResult_i = alu; RDData_i = wd; RDaddr_i = rd;
    RegWrite_i = rw; MemToReg_i = m2r; MemWrite_i = mw;
  endtask

  // Called at posedge+1. One EX/MEM instruction; ack_at = BUSY cycle index carrying ack (0 = never).
  task automatic run_op(input bit ld, input bit st, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input bit rw, input int ack_at,
                        input logic [31:0] rdata, input bit idle_ack);
    int  c, stalls, exp_stalls;
    bit  done, memop, misal, tmo, ok;
    memop = ld | st;
    misal = ALIGN_EN && memop && (alu[1:0] != 2'b00);
    ok    = memop && !misal && (ack_at >= 1) && (ack_at <= TO);
    tmo   = memop && !misal && !ok;
    exp_stalls = (!memop || misal) ? 0 : (ok ? ack_at : TO);
    set_inputs(alu, wd, rd, rw, ld, st);
    c = 0; stalls = 0; done = 1'b0;
    while (!done && c < 40) begin
      mem_bus.ack   = ((c == 0) && idle_ack) || ((c >= 1) && (c == ack_at));
      mem_bus.rdata = (c == ack_at) ? rdata : $urandom;
      @(negedge clk_i);
      if (c == 0) check("req_idle", mem_bus.req, 1'b0);
      else begin
        check("req_busy", mem_bus.req, 1'b1);
        check("addr_busy", mem_bus.addr, alu);
        check("we_busy", mem_bus.we, st);
        if (st) check("wdata_busy", mem_bus.wdata, wd);
      end
      if (stall_o) stalls++; else done = 1'b1;
      @(posedge clk_i); #1;
      c++;
    end
    mem_bus.ack = 1'b0;
    err_model = err_model | tmo;
    check("terminated", done, 1'b1);
    check("stall_cycles", stalls, exp_stalls);
    check("req_after", mem_bus.req, 1'b0);
    check("RegWrite_o", RegWrite_o, rw && !tmo && !misal);
    check("RDaddr_o", RDaddr_o, rd);
    check("ALUResult_o", ALUResult_o, alu);
    check("ReadData_o", ReadData_o, ok ? rdata : 32'h0);
    if (!tmo) check("MemToReg_o", MemToReg_o, ld);
    check("err_o", err_o, err_model);
    check("misalign_o", misalign_o, misal);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    mem_bus.ack = 1'b0; mem_bus.rdata = '0;
    set_inputs(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); @(posedge clk_i); #1;
    err_model = 1'b0;
    check("rst_req", mem_bus.req, 1'b0);
    check("rst_we", mem_bus.we, 1'b0);
    check("rst_addr", mem_bus.addr, 32'h0);
    check("rst_wdata", mem_bus.wdata, 32'h0);
    check("rst_alu", ALUResult_o, 32'h0);
    check("rst_rdata", ReadData_o, 32'h0);
    check("rst_rd", RDaddr_o, 5'd0);
    check("rst_rw", RegWrite_o, 1'b0);
    check("rst_m2r", MemToReg_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_misal", misalign_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    rst_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, r;
    logic [4:0]  rd;
    int          kind, ack_at;
    mem_bus.ack = 1'b0; mem_bus.rdata = '0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    do_reset();

    // ALU op, load with ack 3 cycles after req, store then back-to-back load
    run_op(1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 32'h0, 1'b1);
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 1'b1, 4, 32'hDEADBEEF, 1'b0);
    run_op(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd0, 1'b0, 2, 32'h0BADF00D, 1'b0);
    run_op(1'b1, 1'b0, 32'h84, 32'h0, 5'd9, 1'b1, 1, 32'h600DCAFE, 1'b0);
    // ack on the expiry cycle wins, then a real timeout
    run_op(1'b1, 1'b0, 32'h88, 32'h0, 5'd3, 1'b1, TO, 32'h13579BDF, 1'b0);
    run_op(1'b1, 1'b0, 32'h8C, 32'h0, 5'd4, 1'b1, 0, 32'h0, 1'b0);
    run_op(1'b0, 1'b0, 32'h99, 32'h0, 5'd6, 1'b1, 0, 32'h0, 1'b0);
    do_reset();

    // Reset during BUSY drops req; a later ack is ignored
    set_inputs(32'h100, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("busy_req", mem_bus.req, 1'b1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    set_inputs(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rst_busy_req", mem_bus.req, 1'b0);
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h55AA55AA;
    @(posedge clk_i); #1;
    mem_bus.ack = 1'b0;
    check("late_ack_rdata", ReadData_o, 32'h0);
    check("late_ack_rw", RegWrite_o, 1'b0);
    check("late_ack_req", mem_bus.req, 1'b0);

    if (ALIGN_EN) run_op(1'b1, 1'b0, 32'h41, 32'h0, 5'd2, 1'b1, 2, 32'h1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d  = $urandom;
      r  = $urandom;
      rd = 5'($urandom);
      ack_at = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 3);
      run_op(kind == 1, kind == 2, a, d, rd, $urandom_range(0, 1) == 1, ack_at, r,
             $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
